// File: rtl/mult8_shift_add_seq_if.sv
// Operand/product handshake bundle for the sequential shift-add multiplier.
// master: operand producer and product consumer. slave: the multiplier.
interface mult8_shift_add_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );
endinterface

// File: rtl/mult8_shift_add_seq.sv
// Sequential shift-add unsigned multiplier. One partial-product row per cycle is added into
// the upper half of a 2*WIDTH accumulator (carry kept) and the accumulator shifts right;
// the multiplier bits occupy the low half and are consumed LSB first.
// Optional build macro: MULT_ZERO_SKIP_EN -- a zero operand at accept bypasses the row
// cycles and presents a zero product directly.
module mult8_shift_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mult8_shift_add_seq_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("mult8_shift_add_seq: WIDTH must be in 2..16");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [WIDTH-1:0]     a_r_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;

  logic [WIDTH-1:0]     row;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_next;
  logic                 last_row;

  // Row datapath: gate the multiplicand by the current multiplier bit and add with carry.
  always_comb begin
    row    = p_q[0] ? a_r_q : '0;
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, row};
    p_next = {sum, p_q[WIDTH-1:1]};
  end

  assign last_row = (cnt_q == CntW'(WIDTH - 1));

`ifdef MULT_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`endif

  // Control FSM plus accumulator, latched multiplicand, row counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      p_q         <= '0;
      a_r_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_r_q <= bus.a;
            cnt_q <= '0;
`ifdef MULT_ZERO_SKIP_EN
            if (zero_op) begin
              p_q         <= '0;
              product_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              p_q     <= {{WIDTH{1'b0}}, bus.b};
              state_q <= StRun;
            end
`else
            p_q     <= {{WIDTH{1'b0}}, bus.b};
            state_q <= StRun;
`endif
          end
        end
        StRun: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_row) begin
            // Final row: the product is the accumulator after this shift.
            product_q   <= p_next;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // Handshake flags decode straight from state; product and out_valid come from registers.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_mult8_shift_add_seq.sv
// Directed bench for mult8_shift_add_seq. The driver pushes the hand-computed product into a
// queue on each accepted operand pair; an independent monitor pops and compares on every
// output handshake and checks the product stays stable while stalled.
module tb_mult8_shift_add_seq;
  localparam int unsigned WIDTH = 8;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZeroEdges = 2;
`else
  localparam int ZeroEdges = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;

  mult8_shift_add_seq_if #(.WIDTH(WIDTH)) bus ();

  mult8_shift_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; pushes the expected product on acceptance.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp_p, input bit keep_valid,
                        output int edges);
    bit acc;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    edges = 0;
    do begin
      acc = bus.in_ready;
      tick();
      edges++;
    end while (!acc && edges < 40);
    check("accept", 32'(acc), 32'd1);
    if (acc) exp_q.push_back(exp_p);
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises; in_ready must stay low and busy high meanwhile.
  task automatic wait_valid(input string name, output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      check({name, "_in_ready_run"}, 32'(bus.in_ready), 32'd0);
      check({name, "_busy_run"}, 32'(bus.busy), 32'd1);
      tick();
      edges++;
    end
    check({name, "_out_valid_seen"}, 32'(bus.out_valid), 32'd1);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin : monitor
    bit stalled = 0;
    logic [2*WIDTH-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else if (bus.out_valid) begin
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (stalled) check("product_held", 32'(bus.product), 32'(held));
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, required no output", bus.product);
          end else begin
            check("product", 32'(bus.product), 32'(exp_q.pop_front()));
          end
          stalled = 0;
        end else begin
          stalled = 1;
          held = bus.product;
        end
      end
    end
  end

  initial begin : stimulus
    int e_acc, e_wait, gap;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 0xFF * 0xFF: carry out of each row add must survive.
    bus.out_ready = 1'b1;
    accept(8'hFF, 8'hFF, 16'hFE01, 1'b0, e_acc);
    wait_valid("ffxff", e_wait);
    check("ffxff_latency", 32'(e_wait), 32'(WIDTH));
    tick();
    check("ffxff_total_edges", 32'(e_acc + e_wait + 1), 32'd10);
    check("ffxff_out_valid_after", 32'(bus.out_valid), 32'd0);
    check("ffxff_in_ready_after", 32'(bus.in_ready), 32'd1);

    // 0x0D * 0x0B with a 5-cycle stall in DONE.
    bus.out_ready = 1'b0;
    accept(8'h0D, 8'h0B, 16'h008F, 1'b0, e_acc);
    wait_valid("stall", e_wait);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("stall_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Back-to-back with in_valid held: second accept only after the first handshake.
    bus.out_ready = 1'b1;
    accept(8'h80, 8'h02, 16'h0100, 1'b1, e_acc);
    bus.a = 8'h01;
    bus.b = 8'h01;
    gap = 0;
    while (!bus.in_ready && gap < 40) begin
      tick();
      gap++;
    end
    check("b2b_gap", 32'(gap), 32'(WIDTH + 1));
    exp_q.push_back(16'h0001);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_second_accept", 32'(bus.in_ready), 32'd0);
    wait_valid("b2b", e_wait);
    tick();

    // Operand change during RUN is ignored.
    accept(8'h12, 8'h34, 16'h03A8, 1'b0, e_acc);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.in_valid = 1'b1;
    wait_valid("opchg", e_wait);
    bus.in_valid = 1'b0;
    tick();
    check("opchg_idle", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset at row 4 aborts without presenting anything.
    accept(8'hAA, 8'h55, 16'h3872, 1'b0, e_acc);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    accept(8'h03, 8'h05, 16'h000F, 1'b0, e_acc);
    wait_valid("post_abort", e_wait);
    tick();

    // Zero operand: full row latency unless zero skipping is built in.
    accept(8'h00, 8'hC3, 16'h0000, 1'b0, e_acc);
    wait_valid("zero", e_wait);
    tick();
    check("zero_total_edges", 32'(e_acc + e_wait + 1), 32'(ZeroEdges));
    check("zero_idle", 32'(bus.in_ready), 32'd1);

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end
endmodule
